// File: rtl/frac_div_pkg.sv
// Shared types and constants for the fractional clock divider controller.
package frac_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND,
    STOP
  } state_t;

  typedef logic [3:0] ratio_t;

  localparam ratio_t MIN_INT = 4'd2;

endpackage

// File: rtl/frac_div_core.sv
// Frame counters and waveform generator: one posedge and one negedge toggle flop
// whose XOR forms clk_out, so only one input of the XOR ever changes at a time.
module frac_div_core
  import frac_div_pkg::*;
#(
  parameter int DEF_INT  = 3,
  parameter int DEF_HALF = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  ratio_t n,
  input  logic   h,
  input  logic   run,
  output logic   clk_out,
  output logic   wrap
);

  ratio_t     cur_n;
  logic       cur_h;
  logic [4:0] cnt;
  logic [4:0] cnt_nxt;
  logic [4:0] last;
  logic       active;
  logic       go;
  logic       pos_lvl;
  logic       neg_lvl;
  logic       pos_t;
  logic       neg_t;

  // Level of half-cycle hidx within a frame (even = after posedge, odd = after negedge).
  function automatic logic half_level(input logic [6:0] hidx, input ratio_t nr, input logic hf);
    logic [6:0] n7;
    n7 = {3'b000, nr};
    if (!hf) return hidx < n7;
    return (hidx <= n7) || ((hidx > n7 + n7) && (hidx < n7 + n7 + n7 + 7'd2));
  endfunction

  always_comb begin
    last = cur_h ? {cur_n, 1'b0} : ({1'b0, cur_n} - 5'd1);
    wrap = active && (cnt == last);
    if (!active || wrap) begin
      cnt_nxt = '0;
      go      = run;
    end else begin
      cnt_nxt = cnt + 5'd1;
      go      = 1'b1;
    end
    pos_lvl = go && half_level({1'b0, cnt_nxt, 1'b0}, cur_n, cur_h);
    neg_lvl = active && half_level({1'b0, cnt, 1'b1}, cur_n, cur_h);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_n  <= ratio_t'(DEF_INT);
      cur_h  <= 1'(DEF_HALF);
      cnt    <= '0;
      active <= 1'b0;
      pos_t  <= 1'b0;
    end else begin
      if (load) begin
        cur_n <= n;
        cur_h <= h;
      end
      cnt    <= go ? cnt_nxt : 5'd0;
      active <= go;
      pos_t  <= neg_t ^ pos_lvl;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) neg_t <= 1'b0;
    else     neg_t <= pos_t ^ neg_lvl;
  end

  assign clk_out = pos_t ^ neg_t;

endmodule

// File: rtl/frac_div_ctrl.sv
// Divider control: ratio request handshake, pending ratio, start/stop FSM
// that only switches ratio or halts the core on a frame boundary.
module frac_div_ctrl
  import frac_div_pkg::*;
#(
  parameter int DEF_INT  = 3,
  parameter int DEF_HALF = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [3:0] cfg_int,
  input  logic       cfg_half,
  output logic       clk_out,
  output logic       frame_strobe,
  output logic       busy,
  output logic       cfg_err
);

  state_t state;
  state_t state_nxt;
  ratio_t pend_n;
  logic   pend_h;
  ratio_t ld_n;
  logic   ld_h;
  logic   load;
  logic   capture;
  logic   hs;
  logic   legal;
  logic   run;
  logic   wrap;

  assign cfg_ready = (state == IDLE) || (state == RUN);
  assign busy      = (state == PEND) || (state == STOP);
  assign run       = (state == RUN) || (state == PEND);
  assign hs        = cfg_valid && cfg_ready;
  assign legal     = cfg_int >= MIN_INT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      frame_strobe <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      frame_strobe <= wrap && run;
      cfg_err      <= hs && !legal;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      pend_n <= cfg_int;
      pend_h <= cfg_half;
    end
  end

  // A dropped enable wins over any request or pending ratio.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    ld_n      = pend_n;
    ld_h      = pend_h;
    unique case (state)
      IDLE: begin
        if (hs && legal) begin
          load = 1'b1;
          ld_n = cfg_int;
          ld_h = cfg_half;
        end
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_nxt = STOP;
        end else if (hs && legal) begin
          state_nxt = PEND;
          capture   = 1'b1;
        end
      end
      PEND: begin
        if (!enable) begin
          state_nxt = STOP;
        end else if (wrap) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      STOP: begin
        if (wrap) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  frac_div_core #(
    .DEF_INT (DEF_INT),
    .DEF_HALF(DEF_HALF)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .n      (ld_n),
    .h      (ld_h),
    .run    (run),
    .clk_out(clk_out),
    .wrap   (wrap)
  );

endmodule

// File: tb/tb_frac_div_ctrl.sv
// Bench for frac_div_ctrl: directed scenarios plus random traffic, checked every
// half-cycle against a frame-waveform reference model.
`timescale 1ns/1ps
module tb_frac_div_ctrl;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_PEND = 2;
  localparam int S_STOP = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_int = 4'd0;
  logic       cfg_half = 1'b0;
  logic       clk_out;
  logic       frame_strobe;
  logic       busy;
  logic       cfg_err;

  int    n_checks = 0;
  int    n_fail   = 0;
  string scen     = "reset";

  int   m_state;
  int   m_n;
  int   m_h;
  int   p_n;
  int   p_h;
  bit   m_active;
  bit   lvl_q[$];
  logic e_out;
  logic e_strobe;
  logic e_err;

  frac_div_ctrl #(
    .DEF_INT (3),
    .DEF_HALF(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_int     (cfg_int),
    .cfg_half    (cfg_half),
    .clk_out     (clk_out),
    .frame_strobe(frame_strobe),
    .busy        (busy),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s [%s] t=%0t observed=%b expected=%b", tag, scen, $time, obs, exp);
    end
  endtask

  // One frame of half-cycle levels: H=0 is N high then N low; H=1 is two periods of N+1 high, N low.
  task automatic push_frame(input int n, input int h);
    int reps;
    int hi;
    reps = (h != 0) ? 2 : 1;
    hi   = (h != 0) ? n + 1 : n;
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi; i++) lvl_q.push_back(1'b1);
      for (int i = 0; i < n; i++)  lvl_q.push_back(1'b0);
    end
  endtask

  task automatic model_reset();
    m_state  = S_IDLE;
    m_n      = 3;
    m_h      = 1;
    m_active = 1'b0;
    lvl_q.delete();
    e_out    = 1'b0;
    e_strobe = 1'b0;
    e_err    = 1'b0;
  endtask

  task automatic model_pos();
    bit hs;
    bit legal;
    bit wrap;
    bit run_now;
    hs      = cfg_valid && (m_state == S_IDLE || m_state == S_RUN);
    legal   = (int'(cfg_int) >= 2);
    wrap    = m_active && (lvl_q.size() == 0);
    run_now = (m_state == S_RUN) || (m_state == S_PEND);
    e_err    = hs && !legal;
    e_strobe = wrap && run_now;
    case (m_state)
      S_IDLE: begin
        if (hs && legal) begin
          m_n = int'(cfg_int);
          m_h = int'(cfg_half);
        end
        if (enable) m_state = S_RUN;
      end
      S_RUN: begin
        if (!enable) m_state = S_STOP;
        else if (hs && legal) begin
          p_n = int'(cfg_int);
          p_h = int'(cfg_half);
          m_state = S_PEND;
        end
      end
      S_PEND: begin
        if (!enable) m_state = S_STOP;
        else if (wrap) begin
          m_n = p_n;
          m_h = p_h;
          m_state = S_RUN;
        end
      end
      default: begin
        if (wrap) m_state = S_IDLE;
      end
    endcase
    if (!m_active || wrap) begin
      if (run_now) begin
        push_frame(m_n, m_h);
        m_active = 1'b1;
      end else begin
        m_active = 1'b0;
      end
    end
    e_out = (lvl_q.size() > 0) ? lvl_q.pop_front() : 1'b0;
  endtask

  task automatic model_neg();
    e_out = (lvl_q.size() > 0) ? lvl_q.pop_front() : 1'b0;
  endtask

  always begin
    @(clk or posedge rst);
    if (rst)      model_reset();
    else if (clk) model_pos();
    else          model_neg();
    #1;
    check_val("clk_out", clk_out, e_out);
    if (clk || rst) begin
      check_val("frame_strobe", frame_strobe, e_strobe);
      check_val("cfg_err", cfg_err, e_err);
      check_val("busy", busy, (m_state == S_PEND) || (m_state == S_STOP));
      check_val("cfg_ready", cfg_ready, (m_state == S_IDLE) || (m_state == S_RUN));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic request(input int ni, input int hf);
    cfg_valid = 1'b1;
    cfg_int   = 4'(ni);
    cfg_half  = 1'(hf);
    tick(1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tick(2);

    scen = "defaults";
    enable = 1'b1;
    tick(30);

    scen = "req_5_0";
    request(5, 0);
    tick(40);

    scen = "req_3_1";
    request(3, 1);
    tick(25);

    scen = "req_illegal";
    request(1, 0);
    tick(25);

    scen = "stop_4_1";
    request(4, 1);
    tick(25);
    enable = 1'b0;
    tick(45);

    scen = "rst_mid_high";
    enable = 1'b1;
    tick(10);
    for (int i = 0; i < 20 && clk_out !== 1'b1; i++) tick(1);
    #1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(30);

    scen = "idle_start_2_1";
    enable = 1'b0;
    tick(40);
    enable    = 1'b1;
    request(2, 1);
    tick(30);

    scen = "pend_stop";
    request(6, 0);
    tick(2);
    enable = 1'b0;
    tick(40);

    scen = "random";
    enable = 1'b1;
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_int   = 4'($urandom_range(0, 15));
      cfg_half  = 1'($urandom_range(0, 1));
      tick(1);
    end
    cfg_valid = 1'b0;
    enable    = 1'b0;
    tick(70);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
